// File: rtl/serv_fetch_ctrl.sv
// serv_fetch_ctrl: instruction-fetch sequencer in front of the SERV decoder.
// Runs the ibus Wishbone read, captures the word, and pulses the decoder load
// strobe once per instruction. It holds off the next fetch until execution is
// done, and parks in HALT between instructions for debug.
// Optional feature macro: SERV_FETCH_TIMEOUT_EN (abort a FETCH that gets no ack
// within TIMEOUT_CYCLES cycles and pulse o_fetch_err).
module serv_fetch_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_fetch_req,
  input  logic [31:0] i_pc,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic        o_dec_en,
  output logic [29:0] o_dec_rdt,
  input  logic        i_exec_done,
  input  logic        i_halt_req,
  input  logic        i_resume_req,
  output logic        o_halted,
  output logic        o_busy,
  output logic        o_fetch_err
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, HALT} state_e;

  // Bits [31:2] of addi x0,x0,0 so the decoder sees a NOP out of reset
  localparam logic [29:0] NOP_RDT = 30'h0000_0004;

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic        cyc_q, cyc_d;
  logic [29:0] rdt_q, rdt_d;
  logic        dec_en_q, dec_en_d;
  logic        halted_q, halted_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        halt_pend_q, halt_pend_d;
  logic        unused_ok;

`ifdef SERV_FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  assign unused_ok = ^i_ibus_rdt[1:0];
`else
  assign unused_ok = ^{i_ibus_rdt[1:0], TIMEOUT_CYCLES};
`endif

  // Next-state and next-output logic; every output is taken from a flop
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    cyc_d       = cyc_q;
    rdt_d       = rdt_q;
    dec_en_d    = 1'b0;
    err_d       = 1'b0;
    halt_pend_d = halt_pend_q | (i_halt_req && (state_q != HALT));
`ifdef SERV_FETCH_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (halt_pend_q || i_halt_req) begin
          state_d = HALT;
        end else if (i_fetch_req) begin
          state_d = FETCH;
          adr_d   = i_pc;
          cyc_d   = 1'b1;
`ifdef SERV_FETCH_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      FETCH: begin
        if (i_ibus_ack) begin
          rdt_d    = i_ibus_rdt[31:2];
          cyc_d    = 1'b0;
          dec_en_d = 1'b1;
          state_d  = ISSUE;
`ifdef SERV_FETCH_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          // Give up on the bus; a pending halt is then taken from IDLE
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      ISSUE: state_d = EXEC;
      EXEC: begin
        if (i_exec_done) begin
          if (halt_pend_q || i_halt_req) begin
            state_d = HALT;
          end else if (i_fetch_req) begin
            state_d = FETCH;
            adr_d   = i_pc;
            cyc_d   = 1'b1;
`ifdef SERV_FETCH_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALT: begin
        if (i_resume_req) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
    // The pending halt is consumed by entering HALT
    if (state_d == HALT) halt_pend_d = 1'b0;
    busy_d   = (state_d == FETCH) || (state_d == ISSUE) || (state_d == EXEC);
    halted_d = (state_d == HALT);
  end

  // State and output registers; async reset drops cyc without waiting for a clock
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      adr_q       <= 32'h0;
      cyc_q       <= 1'b0;
      rdt_q       <= NOP_RDT;
      dec_en_q    <= 1'b0;
      halted_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
`ifdef SERV_FETCH_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      cyc_q       <= cyc_d;
      rdt_q       <= rdt_d;
      dec_en_q    <= dec_en_d;
      halted_q    <= halted_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      halt_pend_q <= halt_pend_d;
`ifdef SERV_FETCH_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign o_ibus_adr  = adr_q;
  assign o_ibus_cyc  = cyc_q;
  assign o_dec_en    = dec_en_q;
  assign o_dec_rdt   = rdt_q;
  assign o_halted    = halted_q;
  assign o_busy      = busy_q;
  assign o_fetch_err = err_q;

endmodule
